// File: rtl/ids_pkg.sv
// ids_pkg: shared states, attack codes and record address helper for the IDS batch scheduler
// Ports: none (package).
package ids_pkg;

   typedef enum logic [2:0] {
      IDLE,
      CHECK,
      LAUNCH,
      WAIT_BUSY,
      WAIT_DONE,
      NEXT,
      FINISH
   } state_t;

   localparam logic [5:0] NONE        = 6'h00;
   localparam logic [5:0] ATTACH_REJ  = 6'h01;
   localparam logic [5:0] AUTH_FAIL   = 6'h02;
   localparam logic [5:0] SERVICE_REJ = 6'h03;
   localparam logic [5:0] TAU_REJ     = 6'h04;
   localparam logic [5:0] MALFORMED   = 6'h3F;

   // 16-bit record address; wraps modulo 2^16 by construction
   function automatic logic [15:0] rec_addr(input logic [15:0] base, input logic [15:0] idx,
                                            input logic [15:0] stride);
      return base + idx * stride;
   endfunction

endpackage

// File: rtl/ids_watchdog.sv
// ids_watchdog: loadable down-counter that flags expiry on the last permitted enabled cycle
// Ports: clk, reset (sync, active-high), load/init (reload), en (count this cycle), expired.
module ids_watchdog #(
   parameter int W = 16
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         load,
   input  logic         en,
   input  logic [W-1:0] init,
   output logic         expired
);

   logic [W-1:0] cnt;

   // expiry fires while the final allowed cycle is being counted
   assign expired = en && cnt <= W'(1);

   always_ff @(posedge clk) begin
      if (reset)
         cnt <= '0;
      else if (load)
         cnt <= init;
      else if (en && cnt != '0)
         cnt <= cnt - W'(1);
   end

endmodule

// File: rtl/ids_batch_scheduler.sv
// ids_batch_scheduler: runs the IDS core once per packet record and gathers batch attack statistics
// Ports: clk, reset (sync, active-high); job_valid/job_ready/job_base/job_count host job;
//        core_valid/core_ready/core_base core launch; snoop_we/snoop_data result snoop;
//        done, error, attack_cnt, malformed_cnt, first_attack_idx, last_code batch results.
module ids_batch_scheduler import ids_pkg::*; #(
   parameter logic [15:0] REC_STRIDE = 16'd64,
   parameter logic [15:0] TIMEOUT    = 16'd1024,
   parameter int          CNT_W      = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             job_valid,
   output logic             job_ready,
   input  logic [15:0]      job_base,
   input  logic [CNT_W-1:0] job_count,
   output logic             core_valid,
   input  logic             core_ready,
   output logic [15:0]      core_base,
   input  logic             snoop_we,
   input  logic [31:0]      snoop_data,
   output logic             done,
   output logic             error,
   output logic [CNT_W-1:0] attack_cnt,
   output logic [CNT_W-1:0] malformed_cnt,
   output logic [CNT_W-1:0] first_attack_idx,
   output logic [5:0]       last_code
);

   state_t           state;
   logic [15:0]      base;
   logic [CNT_W-1:0] count;
   logic [CNT_W-1:0] rec_idx;
   logic             waiting;
   logic             expired;
   logic             hit;
   logic [5:0]       code;
   logic             snoop_unused;

   assign waiting      = state == WAIT_BUSY || state == WAIT_DONE;
   assign code         = snoop_data[5:0];
   assign hit          = waiting && snoop_we && code != NONE;
   assign snoop_unused = ^snoop_data[31:6];

   ids_watchdog #(.W(16)) u_watchdog (
      .clk     (clk),
      .reset   (reset),
      .load    (state == LAUNCH && core_ready),
      .en      (waiting),
      .init    (TIMEOUT),
      .expired (expired)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         state            <= IDLE;
         job_ready        <= 1'b1;
         core_valid       <= 1'b0;
         core_base        <= '0;
         done             <= 1'b0;
         error            <= 1'b0;
         attack_cnt       <= '0;
         malformed_cnt    <= '0;
         first_attack_idx <= '1;
         last_code        <= '0;
         base             <= '0;
         count            <= '0;
         rec_idx          <= '0;
      end else begin
         core_valid <= 1'b0;
         done       <= 1'b0;
         // snoop runs alongside the FSM so a write coinciding with core_ready is still counted
         if (hit) begin
            attack_cnt <= &attack_cnt ? attack_cnt : attack_cnt + CNT_W'(1);
            last_code  <= code;
            if (&first_attack_idx)
               first_attack_idx <= rec_idx;
            if (code == MALFORMED && !(&malformed_cnt))
               malformed_cnt <= malformed_cnt + CNT_W'(1);
         end
         case (state)
            IDLE:
               if (job_valid && job_ready) begin
                  base             <= job_base;
                  count            <= job_count;
                  rec_idx          <= '0;
                  job_ready        <= 1'b0;
                  error            <= 1'b0;
                  attack_cnt       <= '0;
                  malformed_cnt    <= '0;
                  first_attack_idx <= '1;
                  last_code        <= '0;
                  state            <= CHECK;
               end
            CHECK:
               if (rec_idx == count) begin
                  done  <= 1'b1;
                  state <= FINISH;
               end else begin
                  core_base <= rec_addr(base, 16'(rec_idx), REC_STRIDE);
                  state     <= LAUNCH;
               end
            LAUNCH:
               if (core_ready) begin
                  core_valid <= 1'b1;
                  state      <= WAIT_BUSY;
               end
            WAIT_BUSY:
               if (expired) begin
                  error <= 1'b1;
                  done  <= 1'b1;
                  state <= FINISH;
               end else if (!core_ready)
                  state <= WAIT_DONE;
            WAIT_DONE:
               if (expired) begin
                  error <= 1'b1;
                  done  <= 1'b1;
                  state <= FINISH;
               end else if (core_ready)
                  state <= NEXT;
            NEXT: begin
               rec_idx <= rec_idx + CNT_W'(1);
               state   <= CHECK;
            end
            FINISH: begin
               job_ready <= 1'b1;
               state     <= IDLE;
            end
            default:
               state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_ids_batch_scheduler.sv
// tb_ids_batch_scheduler: randomized scoreboard bench for the IDS batch scheduler
module tb_ids_batch_scheduler;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        job_valid = 1'b0;
   logic        core_ready = 1'b1;
   logic        snoop_we = 1'b0;
   logic [15:0] job_base = '0;
   logic [7:0]  job_count = '0;
   logic [31:0] snoop_data = '0;
   logic        job_ready, core_valid, done, error;
   logic [15:0] core_base;
   logic [7:0]  attack_cnt, malformed_cnt, first_attack_idx;
   logic [5:0]  last_code;

   ids_batch_scheduler #(.REC_STRIDE(16'd64), .TIMEOUT(16'd16), .CNT_W(8)) dut (
      .clk              (clk),
      .reset            (reset),
      .job_valid        (job_valid),
      .job_ready        (job_ready),
      .job_base         (job_base),
      .job_count        (job_count),
      .core_valid       (core_valid),
      .core_ready       (core_ready),
      .core_base        (core_base),
      .snoop_we         (snoop_we),
      .snoop_data       (snoop_data),
      .done             (done),
      .error            (error),
      .attack_cnt       (attack_cnt),
      .malformed_cnt    (malformed_cnt),
      .first_attack_idx (first_attack_idx),
      .last_code        (last_code)
   );

   always #5 clk = ~clk;

   typedef struct {
      int attack;
      int malformed;
      int first;
      int last;
      int err;
   } stats_t;

   int          cyc = 0;
   int          passed = 0;
   int          total = 0;
   logic [15:0] exp_base[$];
   stats_t      exp_stats[$];
   int          plan_code[256];
   int          plan_lat[256];
   int          stall_idx = -1;
   int          launch_k = 0;
   int          last_launch_cyc = 0;
   logic        prev_cv = 1'b0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input int act, input int exp);
      total++;
      if (act == exp)
         passed++;
      else
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
   endtask

   function automatic int rand_code();
      int r;
      r = int'($urandom_range(0, 5));
      return r == 0 ? 0 : r == 1 ? 63 : int'($urandom_range(1, 62));
   endfunction

   // monitor: pops expected launches and batch results whenever the DUT presents them
   always @(negedge clk) begin
      stats_t e;
      if (!reset) begin
         if (core_valid) begin
            last_launch_cyc = cyc;
            chk("launch_expected", int'(exp_base.size() > 0), 1);
            if (exp_base.size() > 0)
               chk("core_base", int'(core_base), int'(exp_base.pop_front()));
            chk("core_valid_single", int'(prev_cv), 0);
         end
         if (done) begin
            chk("done_expected", int'(exp_stats.size() > 0), 1);
            if (exp_stats.size() > 0) begin
               e = exp_stats.pop_front();
               chk("attack_cnt", int'(attack_cnt), e.attack);
               chk("malformed_cnt", int'(malformed_cnt), e.malformed);
               chk("first_attack_idx", int'(first_attack_idx), e.first);
               chk("last_code", int'(last_code), e.last);
               chk("error", int'(error), e.err);
            end
         end
      end
      prev_cv = core_valid;
   end

   // core model: drops ready after a launch, writes one result, raises ready after plan_lat cycles
   initial begin
      int k, lat, w;
      forever begin
         @(negedge clk);
         if (core_valid && !reset) begin
            k = launch_k;
            launch_k++;
            if (k == stall_idx) begin
               core_ready = 1'b0;
               while (!done && !reset) @(negedge clk);
               core_ready = 1'b1;
            end else begin
               lat = plan_lat[k];
               w = int'($urandom_range(0, lat));
               for (int i = 0; i <= lat; i++) begin
                  core_ready = (i == lat);
                  snoop_we   = (i == w);
                  snoop_data = {26'($urandom()), 6'(plan_code[k])};
                  @(negedge clk);
               end
               snoop_we = 1'b0;
            end
         end
      end
   end

   // reference: launches stop after the stalled record; only completed records report codes
   task automatic run_job(input logic [15:0] b, input int n, input int stall, input int rst_after);
      stats_t e;
      int     proc, t, t2;
      proc = stall >= 0 ? stall : n;
      e.attack = 0; e.malformed = 0; e.first = 255; e.last = 0; e.err = int'(stall >= 0);
      for (int i = 0; i < n; i++)
         if (stall < 0 || i <= stall) exp_base.push_back(b + 16'(i * 64));
      for (int i = 0; i < proc; i++)
         if (plan_code[i] != 0) begin
            e.attack++;
            if (plan_code[i] == 63) e.malformed++;
            if (e.first == 255) e.first = i;
            e.last = plan_code[i];
         end
      if (rst_after < 0) exp_stats.push_back(e);
      stall_idx = stall;
      launch_k  = 0;
      @(negedge clk);
      chk("job_ready_idle", int'(job_ready), 1);
      job_base  = b;
      job_count = 8'(n);
      job_valid = 1'b1;
      t = cyc;
      @(negedge clk);
      job_valid = 1'b0;
      chk("job_ready_busy", int'(job_ready), 0);
      if (rst_after >= 0) begin
         for (t2 = 0; t2 < 500 && launch_k <= stall; t2++) @(negedge clk);
         repeat (rst_after) @(negedge clk);
         reset = 1'b1;
         @(negedge clk);
         chk("rst_job_ready", int'(job_ready), 1);
         chk("rst_core_valid", int'(core_valid), 0);
         chk("rst_done", int'(done), 0);
         chk("rst_attack", int'(attack_cnt), 0);
         chk("rst_first", int'(first_attack_idx), 255);
         chk("rst_error", int'(error), 0);
         reset = 1'b0;
         chk("rst_launches", exp_base.size(), 0);
         repeat (4) @(negedge clk);
      end else begin
         for (t2 = 0; t2 < 2000 && !done; t2++) @(negedge clk);
         chk("done_seen", int'(done), 1);
         if (n == 0) chk("zero_done_latency", cyc - t, 2);
         if (stall >= 0) chk("watchdog_latency", cyc - last_launch_cyc, 16);
         @(negedge clk);
         chk("done_one_cycle", int'(done), 0);
         chk("job_ready_after_done", int'(job_ready), 1);
         chk("launches_complete", exp_base.size(), 0);
         chk("hold_attack", int'(attack_cnt), e.attack);
      end
   endtask

   task automatic rand_plan(input int n);
      for (int i = 0; i < n; i++) begin
         plan_code[i] = rand_code();
         plan_lat[i]  = int'($urandom_range(1, 8));
      end
   endtask

   initial begin
      int n;
      repeat (3) @(negedge clk);
      chk("reset_job_ready", int'(job_ready), 1);
      chk("reset_core_valid", int'(core_valid), 0);
      chk("reset_core_base", int'(core_base), 0);
      chk("reset_done", int'(done), 0);
      chk("reset_error", int'(error), 0);
      chk("reset_attack", int'(attack_cnt), 0);
      chk("reset_malformed", int'(malformed_cnt), 0);
      chk("reset_first", int'(first_attack_idx), 255);
      chk("reset_last", int'(last_code), 0);
      reset = 1'b0;
      rand_plan(16);
      plan_code[0] = 0; plan_code[1] = 2; plan_code[2] = 0;
      run_job(16'h0100, 3, -1, -1);
      run_job(16'h1234, 0, -1, -1);
      chk("zero_first", int'(first_attack_idx), 255);
      rand_plan(16);
      run_job(16'h0200, 4, 1, -1);
      rand_plan(16);
      plan_code[0] = 63; plan_code[1] = 4; plan_code[2] = 63;
      run_job(16'h0300, 3, -1, -1);
      rand_plan(16);
      plan_code[0] = 5; plan_code[1] = 63;
      run_job(16'h0400, 4, 2, 3);
      rand_plan(16);
      run_job(16'($urandom()), 5, -1, -1);
      rand_plan(16);
      plan_code[0] = 1; plan_code[1] = 0;
      run_job(16'hFFC0, 2, -1, -1);
      @(negedge clk);
      snoop_we   = 1'b1;
      snoop_data = 32'h0000_0015;
      @(negedge clk);
      snoop_we = 1'b0;
      @(negedge clk);
      chk("idle_snoop_ignored", int'(attack_cnt), 1);
      for (int j = 0; j < 8; j++) begin
         n = int'($urandom_range(1, 10));
         rand_plan(n);
         run_job(16'($urandom()), n, -1, -1);
      end
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL global_timeout: got no finish expected finish");
      $fatal(1, "simulation time limit");
   end

endmodule
